axil_counter_regs: RTL



---
 rtl/axil_counter_regs.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/axil_counter_regs.sv
// AXI4-Lite register block holding NUM_CNT event counters. It supports atomic 64-bit reads
// through a shared high-word shadow, clear-on-read, saturate/wrap, freeze and a global clear.
module axil_counter_regs #(
  parameter logic [31:0] C_BASE_ADDRESS = 32'h0000_0000,
  parameter int          NUM_CNT        = 4,
  parameter int          CNT_WIDTH      = 32,
  parameter int          INC_WIDTH      = 8,
  parameter logic [31:0] ID_VALUE       = 32'h0000_0000,
  parameter logic [31:0] VERSION_VALUE  = 32'h0000_0001
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic [NUM_CNT-1:0]           inc_en,
  input  logic [NUM_CNT*INC_WIDTH-1:0] inc_val,
  output logic [31:0]                  ctrl_out,
  output logic                         ovf_any,
  input  logic [31:0]                  S_AXI_AWADDR,
  input  logic                         S_AXI_AWVALID,
  output logic                         S_AXI_AWREADY,
  input  logic [31:0]                  S_AXI_WDATA,
  input  logic [3:0]                   S_AXI_WSTRB,
  input  logic                         S_AXI_WVALID,
  output logic                         S_AXI_WREADY,
  output logic [1:0]                   S_AXI_BRESP,
  output logic                         S_AXI_BVALID,
  input  logic                         S_AXI_BREADY,
  input  logic [31:0]                  S_AXI_ARADDR,
  input  logic                         S_AXI_ARVALID,
  output logic                         S_AXI_ARREADY,
  output logic [31:0]                  S_AXI_RDATA,
  output logic [1:0]                   S_AXI_RRESP,
  output logic                         S_AXI_RVALID,
  input  logic                         S_AXI_RREADY
);

  localparam int          SUM_W     = CNT_WIDTH + 1;
  localparam logic [28:0] CNT_DW_LO = 29'd4;
  localparam logic [28:0] CNT_DW_HI = 29'(NUM_CNT + 4);

  logic                 aw_ready_r, b_valid_r, ar_ready_r, r_valid_r, ovf_any_r;
  logic [31:0]          ar_addr_r, r_data_r, shadow_r;
  logic [2:0]           ctrl_r;
  logic [NUM_CNT-1:0]   ovf_r, ovf_next_s, ovf_set_s, cor_sel_s;
  logic [CNT_WIDTH-1:0] cnt_r      [NUM_CNT];
  logic [CNT_WIDTH-1:0] cnt_next_s [NUM_CNT];
  logic [31:0]          wr_off_s, rd_off_s, w1c_mask_s, rd_data_s;
  logic [28:0]          rd_dw_s, rd_idx_s;
  logic [63:0]          sel_cnt_s;
  logic                 wr_en_s, rd_en_s, clear_all_s, ctrl_wr_s, ovf_wr_s;
  logic                 rd_is_cnt_s, rd_hi_s, rd_lo_s, inc_s, unused_s;
  logic [INC_WIDTH-1:0] val_s;
  logic [SUM_W-1:0]     sum_s;

  assign S_AXI_AWREADY = aw_ready_r;
  assign S_AXI_WREADY  = aw_ready_r;
  assign S_AXI_BVALID  = b_valid_r;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = ar_ready_r;
  assign S_AXI_RVALID  = r_valid_r;
  assign S_AXI_RDATA   = r_data_r;
  assign S_AXI_RRESP   = 2'b00;
  assign ctrl_out      = {29'd0, ctrl_r};
  assign ovf_any       = ovf_any_r;

  // Register side effects happen in the single cycle the READY pulse is high.
  assign wr_en_s     = aw_ready_r;
  assign rd_en_s     = ar_ready_r;
  assign wr_off_s    = S_AXI_AWADDR ^ C_BASE_ADDRESS;
  assign rd_off_s    = ar_addr_r ^ C_BASE_ADDRESS;
  assign clear_all_s = wr_en_s & (wr_off_s[31:2] == 30'h3);
  assign ctrl_wr_s   = wr_en_s & (wr_off_s[31:2] == 30'h2) & S_AXI_WSTRB[0];
  assign ovf_wr_s    = wr_en_s & (wr_off_s[31:2] == 30'h4);
  assign w1c_mask_s  = S_AXI_WDATA & {{8{S_AXI_WSTRB[3]}}, {8{S_AXI_WSTRB[2]}},
                                      {8{S_AXI_WSTRB[1]}}, {8{S_AXI_WSTRB[0]}}};
  assign rd_dw_s     = rd_off_s[31:3];
  assign rd_is_cnt_s = (rd_dw_s >= CNT_DW_LO) && (rd_dw_s < CNT_DW_HI);
  assign rd_idx_s    = rd_dw_s - CNT_DW_LO;
  assign rd_hi_s     = rd_off_s[2];
  assign rd_lo_s     = rd_en_s & rd_is_cnt_s & ~rd_hi_s;
  assign unused_s    = ^{wr_off_s[1:0], rd_off_s[1:0], w1c_mask_s};

  // Selected counter, zero-extended to 64 bits, plus the clear-on-read targets.
  always_comb begin
    sel_cnt_s = 64'd0;
    cor_sel_s = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      sel_cnt_s    = (rd_idx_s == 29'(i)) ? 64'(cnt_r[i]) : sel_cnt_s;
      cor_sel_s[i] = rd_lo_s & ctrl_r[0] & (rd_idx_s == 29'(i));
    end
  end

  // Read data multiplexer.
  always_comb begin
    rd_data_s = 32'hDEAD_BEEF;
    case (rd_off_s[31:2])
      30'h0:   rd_data_s = ID_VALUE;
      30'h1:   rd_data_s = VERSION_VALUE;
      30'h2:   rd_data_s = {29'd0, ctrl_r};
      30'h3:   rd_data_s = 32'h0000_0000;
      30'h4:   rd_data_s = 32'(ovf_r);
      default: begin
        if (rd_is_cnt_s) begin
          rd_data_s = rd_hi_s ? shadow_r : sel_cnt_s[31:0];
        end else begin
          rd_data_s = 32'hDEAD_BEEF;
        end
      end
    endcase
  end

  // Counter next state: clear-all beats clear-on-read beats increment; overflow sets OVF.
  always_comb begin
    ovf_set_s = '0;
    inc_s     = 1'b0;
    val_s     = '0;
    sum_s     = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      inc_s         = inc_en[i] & ~ctrl_r[2];
      val_s         = inc_val[i*INC_WIDTH +: INC_WIDTH];
      sum_s         = {1'b0, cnt_r[i]} + SUM_W'(val_s);
      cnt_next_s[i] = cnt_r[i];
      if (clear_all_s) begin
        cnt_next_s[i] = '0;
      end else if (cor_sel_s[i]) begin
        cnt_next_s[i] = inc_s ? CNT_WIDTH'(val_s) : '0;
      end else if (inc_s) begin
        if (sum_s[CNT_WIDTH]) begin
          ovf_set_s[i]  = 1'b1;
          cnt_next_s[i] = ctrl_r[1] ? '1 : sum_s[CNT_WIDTH-1:0];
        end else begin
          cnt_next_s[i] = sum_s[CNT_WIDTH-1:0];
        end
      end else begin
        cnt_next_s[i] = cnt_r[i];
      end
    end
  end

  // Sticky overflow: W1C is applied first so a same-cycle overflow wins.
  always_comb begin
    ovf_next_s = ovf_r;
    if (clear_all_s) begin
      ovf_next_s = '0;
    end else if (ovf_wr_s) begin
      ovf_next_s = (ovf_r & ~w1c_mask_s[NUM_CNT-1:0]) | ovf_set_s;
    end else begin
      ovf_next_s = ovf_r | ovf_set_s;
    end
  end

  // AXI handshakes and registered read data.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      aw_ready_r <= 1'b0;
      b_valid_r  <= 1'b0;
      ar_ready_r <= 1'b0;
      r_valid_r  <= 1'b0;
      ar_addr_r  <= 32'd0;
      r_data_r   <= 32'd0;
    end else begin
      aw_ready_r <= S_AXI_AWVALID & S_AXI_WVALID & ~b_valid_r & ~aw_ready_r;
      if (aw_ready_r) begin
        b_valid_r <= 1'b1;
      end else if (S_AXI_BREADY) begin
        b_valid_r <= 1'b0;
      end
      ar_ready_r <= S_AXI_ARVALID & ~ar_ready_r & ~r_valid_r;
      if (S_AXI_ARVALID & ~ar_ready_r & ~r_valid_r) begin
        ar_addr_r <= S_AXI_ARADDR;
      end
      if (ar_ready_r) begin
        r_valid_r <= 1'b1;
        r_data_r  <= rd_data_s;
      end else if (S_AXI_RREADY) begin
        r_valid_r <= 1'b0;
      end
    end
  end

  // Control, status, shadow and counter storage.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ctrl_r    <= 3'd0;
      ovf_r     <= '0;
      ovf_any_r <= 1'b0;
      shadow_r  <= 32'd0;
      for (int i = 0; i < NUM_CNT; i++) begin
        cnt_r[i] <= '0;
      end
    end else begin
      if (ctrl_wr_s) begin
        ctrl_r <= S_AXI_WDATA[2:0];
      end
      ovf_r     <= ovf_next_s;
      ovf_any_r <= |ovf_next_s;
      if (rd_lo_s) begin
        shadow_r <= sel_cnt_s[63:32];
      end
      for (int i = 0; i < NUM_CNT; i++) begin
        cnt_r[i] <= cnt_next_s[i];
      end
    end
  end

endmodule
